// File: rtl/kernel_frame_ctrl_pkg.sv
// Shared definitions for the kernel frame sequencer: stream type codes, FSM states, error bit indices.
// Stream type codes mirror the dtypes.v encodings used by the kernel stream.
package kernel_frame_ctrl_pkg;

  localparam int DTYPE_WIDTH = 8;

  localparam logic [DTYPE_WIDTH-1:0] DTYPE_PIXEL_MASK   = 8'h0F;
  localparam logic [DTYPE_WIDTH-1:0] DTYPE_HEADER_START = 8'h10;
  localparam logic [DTYPE_WIDTH-1:0] DTYPE_HEADER_DATA  = 8'h20;
  localparam logic [DTYPE_WIDTH-1:0] DTYPE_FRAME_START  = 8'h30;
  localparam logic [DTYPE_WIDTH-1:0] DTYPE_FRAME_END    = 8'h40;
  localparam logic [DTYPE_WIDTH-1:0] DTYPE_ROW_START    = 8'h50;
  localparam logic [DTYPE_WIDTH-1:0] DTYPE_ROW_END      = 8'h60;

  localparam int KFC_ERR_LEN   = 0;
  localparam int KFC_ERR_TRUNC = 1;
  localparam int KFC_ERR_STRAY = 2;

  typedef enum logic [1:0] {
    KFC_IDLE   = 2'd0,
    KFC_HEADER = 2'd1,
    KFC_FRAME  = 2'd2,
    KFC_ROW    = 2'd3
  } kfc_state_t;

  function automatic logic is_pixel(input logic [DTYPE_WIDTH-1:0] dt);
    return |(dt & DTYPE_PIXEL_MASK);
  endfunction

endpackage

// File: rtl/kernel_frame_ctrl.sv
// Tracks stream phase, applies kernel enable only between frames, measures frame geometry and flags malformed frames.
// All outputs registered: each reflects its event one cycle after the dvi cycle.
module kernel_frame_ctrl
  import kernel_frame_ctrl_pkg::*;
#(
  parameter int COUNT_WIDTH = 16,
  parameter int MAX_COLS    = 1288
) (
  input  logic                   clk,
  input  logic                   resetb,
  input  logic                   dvi,
  input  logic [DTYPE_WIDTH-1:0] dtypei,
  input  logic                   enable_req,
  input  logic                   err_clr,
  output logic                   enable,
  output logic                   busy,
  output logic [COUNT_WIDTH-1:0] num_cols,
  output logic [COUNT_WIDTH-1:0] num_rows,
  output logic [COUNT_WIDTH-1:0] frame_count,
  output logic [2:0]             err
);

  kfc_state_t             r_state;
  kfc_state_t             w_state_nxt;
  logic                   r_enable;
  logic                   r_busy;
  logic [COUNT_WIDTH-1:0] r_col_cnt;
  logic [COUNT_WIDTH-1:0] r_row_cnt;
  logic [COUNT_WIDTH-1:0] r_ref_cols;
  logic [COUNT_WIDTH-1:0] r_num_cols;
  logic [COUNT_WIDTH-1:0] r_num_rows;
  logic [COUNT_WIDTH-1:0] r_frame_count;
  logic [2:0]             r_err;

  logic       w_pix;
  logic       w_restart;
  logic       w_row_start;
  logic       w_row_end;
  logic       w_pix_inc;
  logic       w_frame_done;
  logic [2:0] w_err_set;
  logic       w_len_bad;

  assign w_pix = is_pixel(dtypei);

  // Width check uses the count as it stands on the ROW_END cycle (ROW_END is never a pixel).
  assign w_len_bad = ((r_row_cnt != '0) && (r_col_cnt != r_ref_cols)) ||
                     (r_col_cnt > COUNT_WIDTH'(MAX_COLS));

  always_comb begin
    w_state_nxt  = r_state;
    w_restart    = 1'b0;
    w_row_start  = 1'b0;
    w_row_end    = 1'b0;
    w_pix_inc    = 1'b0;
    w_frame_done = 1'b0;
    w_err_set    = '0;
    if (dvi) begin
      if (w_pix && (r_state != KFC_ROW)) w_err_set[KFC_ERR_STRAY] = 1'b1;
      case (r_state)
        KFC_IDLE: begin
          if (dtypei == DTYPE_HEADER_START) begin
            w_state_nxt = KFC_HEADER;
          end else if (dtypei == DTYPE_FRAME_START) begin
            w_state_nxt = KFC_FRAME;
            w_restart   = 1'b1;
          end
        end
        KFC_HEADER: begin
          if (dtypei == DTYPE_FRAME_START) begin
            w_state_nxt = KFC_FRAME;
            w_restart   = 1'b1;
          end
        end
        KFC_FRAME: begin
          if (dtypei == DTYPE_ROW_START) begin
            w_state_nxt = KFC_ROW;
            w_row_start = 1'b1;
          end else if (dtypei == DTYPE_FRAME_END) begin
            w_state_nxt  = KFC_IDLE;
            w_frame_done = 1'b1;
          end else if (dtypei == DTYPE_FRAME_START) begin
            w_restart                = 1'b1;
            w_err_set[KFC_ERR_TRUNC] = 1'b1;
          end
        end
        KFC_ROW: begin
          if (w_pix) begin
            w_pix_inc = 1'b1;
          end else if (dtypei == DTYPE_ROW_END) begin
            w_state_nxt            = KFC_FRAME;
            w_row_end              = 1'b1;
            w_err_set[KFC_ERR_LEN] = w_len_bad;
          end else if (dtypei == DTYPE_FRAME_END) begin
            w_state_nxt              = KFC_IDLE;
            w_err_set[KFC_ERR_TRUNC] = 1'b1;
          end else if (dtypei == DTYPE_FRAME_START) begin
            w_state_nxt              = KFC_FRAME;
            w_restart                = 1'b1;
            w_err_set[KFC_ERR_TRUNC] = 1'b1;
          end
        end
        default: w_state_nxt = KFC_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!resetb) begin
      r_state  <= KFC_IDLE;
      r_enable <= 1'b0;
      r_busy   <= 1'b0;
      r_err    <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_busy  <= (w_state_nxt != KFC_IDLE);
      // Enable only tracks the request while idle, so a frame never sees it change.
      if (r_state == KFC_IDLE) r_enable <= enable_req;
      r_err <= (err_clr ? 3'b000 : r_err) | w_err_set;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetb) begin
      r_col_cnt     <= '0;
      r_row_cnt     <= '0;
      r_ref_cols    <= '0;
      r_num_cols    <= '0;
      r_num_rows    <= '0;
      r_frame_count <= '0;
    end else begin
      if (w_restart) begin
        r_col_cnt  <= '0;
        r_row_cnt  <= '0;
        r_ref_cols <= '0;
      end else begin
        if (w_row_start) r_col_cnt <= '0;
        if (w_pix_inc && (r_col_cnt != '1)) r_col_cnt <= r_col_cnt + 1'b1;
        if (w_row_end) begin
          if (r_row_cnt == '0) r_ref_cols <= r_col_cnt;
          if (r_row_cnt != '1) r_row_cnt <= r_row_cnt + 1'b1;
        end
      end
      if (w_frame_done) begin
        r_num_rows    <= r_row_cnt;
        r_num_cols    <= r_ref_cols;
        r_frame_count <= r_frame_count + 1'b1;
      end
    end
  end

  assign enable      = r_enable;
  assign busy        = r_busy;
  assign num_cols    = r_num_cols;
  assign num_rows    = r_num_rows;
  assign frame_count = r_frame_count;
  assign err         = r_err;

endmodule

// File: tb/tb_kernel_frame_ctrl.sv
// Bench for kernel_frame_ctrl: frames described as lists of row lengths, expectations derived per frame.
// Stimulus randomises geometry, idle gaps, headers, enable requests and truncations.
module tb_kernel_frame_ctrl;
  import kernel_frame_ctrl_pkg::*;

  localparam int CW   = 16;
  localparam int MAXC = 1288;

  logic                   clk = 1'b0;
  logic                   resetb = 1'b0;
  logic                   dvi = 1'b0;
  logic [DTYPE_WIDTH-1:0] dtypei = '0;
  logic                   enable_req = 1'b0;
  logic                   err_clr = 1'b0;
  logic                   enable;
  logic                   busy;
  logic [CW-1:0]          num_cols;
  logic [CW-1:0]          num_rows;
  logic [CW-1:0]          frame_count;
  logic [2:0]             err;

  kernel_frame_ctrl #(.COUNT_WIDTH(CW), .MAX_COLS(MAXC)) dut (
    .clk(clk), .resetb(resetb), .dvi(dvi), .dtypei(dtypei),
    .enable_req(enable_req), .err_clr(err_clr), .enable(enable), .busy(busy),
    .num_cols(num_cols), .num_rows(num_rows), .frame_count(frame_count), .err(err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference state: what firmware should see after each completed frame.
  logic [CW-1:0] exp_fc   = '0;
  logic [CW-1:0] exp_rows = '0;
  logic [CW-1:0] exp_cols = '0;
  logic [2:0]    exp_err  = '0;

  // Frame description for send_frame.
  int rows_q[$];
  int trunc_at   = -1;
  int clr_at_row = -1;
  int req_start  = -1;
  int req_mid    = -1;
  bit skip_gap   = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic cyc(input bit dv, input logic [DTYPE_WIDTH-1:0] dt);
    dvi    = dv;
    dtypei = dt;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [DTYPE_WIDTH-1:0] pix_type();
    logic [3:0] m;
    m = 4'b0001 << $urandom_range(0, 3);
    return {4'h0, m};
  endfunction

  task automatic idle_gap();
    cyc(1'b0, DTYPE_WIDTH'($urandom));
  endtask

  task automatic do_reset();
    resetb = 1'b0;
    enable_req = 1'b0;
    cyc(1'b0, '0);
    cyc(1'b0, '0);
    exp_fc = '0; exp_rows = '0; exp_cols = '0; exp_err = '0;
    check("rst_enable", enable, 0);
    check("rst_busy", busy, 0);
    check("rst_cols", num_cols, 0);
    check("rst_rows", num_rows, 0);
    check("rst_fc", frame_count, 0);
    check("rst_err", err, 0);
    resetb = 1'b1;
    cyc(1'b0, '0);
  endtask

  task automatic send_frame(input bit hdr);
    bit en_frame;
    bit truncated;
    int len;
    truncated  = 1'b0;
    enable_req = (req_start < 0) ? 1'($urandom_range(0, 1)) : 1'(req_start);
    en_frame   = enable_req;
    if (hdr) begin
      cyc(1'b1, DTYPE_HEADER_START);
      cyc(1'b1, DTYPE_HEADER_DATA);
      cyc(1'b0, pix_type());
    end
    cyc(1'b1, DTYPE_FRAME_START);
    check("busy_fs", busy, 1);
    check("en_fs", enable, en_frame);
    for (int r = 0; r < rows_q.size(); r++) begin
      len = rows_q[r];
      cyc(1'b1, DTYPE_ROW_START);
      for (int p = 0; p < len; p++) begin
        if ($urandom_range(0, 4) == 0) idle_gap();
        cyc(1'b1, pix_type());
      end
      enable_req = (req_mid < 0) ? 1'($urandom_range(0, 1)) : 1'(req_mid);
      if (r == trunc_at) begin
        cyc(1'b1, DTYPE_FRAME_END);
        exp_err[KFC_ERR_TRUNC] = 1'b1;
        truncated = 1'b1;
        break;
      end
      if (r == clr_at_row) err_clr = 1'b1;
      cyc(1'b1, DTYPE_ROW_END);
      err_clr = 1'b0;
      if (r == clr_at_row) exp_err = '0;
      if ((r > 0 && len != rows_q[0]) || len > MAXC) exp_err[KFC_ERR_LEN] = 1'b1;
      check("err_row", err, exp_err);
      check("en_hold", enable, en_frame);
    end
    if (!truncated) begin
      cyc(1'b1, DTYPE_FRAME_END);
      exp_fc++;
      exp_rows = CW'(rows_q.size());
      exp_cols = CW'(rows_q[0]);
    end
    check("busy_fe", busy, 0);
    check("en_fe", enable, en_frame);
    check("fc", frame_count, exp_fc);
    check("rows", num_rows, exp_rows);
    check("cols", num_cols, exp_cols);
    check("err_fe", err, exp_err);
    if (!skip_gap) begin
      enable_req = (req_mid < 0) ? 1'($urandom_range(0, 1)) : 1'(req_mid);
      idle_gap();
      check("en_idle", enable, enable_req);
    end
  endtask

  task automatic clear_err();
    err_clr = 1'b1;
    idle_gap();
    err_clr = 1'b0;
    exp_err = '0;
    check("err_clr", err, 0);
  endtask

  initial begin
    do_reset();

    // Clean 4x6 frame.
    rows_q = '{6, 6, 6, 6};
    send_frame(1'b0);
    check("t1_cols", num_cols, 6);
    check("t1_rows", num_rows, 4);

    // Enable requested mid-frame lands only after FRAME_END; next frame runs enabled.
    req_start = 0; req_mid = 1;
    send_frame(1'b0);
    req_start = 1;
    send_frame(1'b1);
    req_start = -1; req_mid = -1;

    // Row 2 short by one pixel.
    rows_q = '{6, 6, 5, 6};
    send_frame(1'b0);
    check("t3_err", err, 3'b001);
    clear_err();

    // FRAME_END inside a row, then a clean frame.
    rows_q = '{3, 3, 3};
    trunc_at = 1;
    send_frame(1'b0);
    trunc_at = -1;
    check("t4_err", err, 3'b010);
    send_frame(1'b1);
    clear_err();

    // Stray pixel while idle, then err_clr colliding with a new length error.
    cyc(1'b1, pix_type());
    exp_err[KFC_ERR_STRAY] = 1'b1;
    check("stray", err, 3'b100);
    rows_q = '{6, 6, 5, 6};
    clr_at_row = 2;
    send_frame(1'b0);
    clr_at_row = -1;
    check("clr_collide", err, 3'b001);
    clear_err();

    // Back-to-back FRAME_END / FRAME_START.
    rows_q = '{2, 2};
    skip_gap = 1'b1;
    send_frame(1'b0);
    skip_gap = 1'b0;
    send_frame(1'b0);

    // Over-long single row.
    rows_q = '{1300};
    send_frame(1'b0);
    check("maxcols", err[KFC_ERR_LEN], 1);
    clear_err();

    // Randomised frames.
    for (int f = 0; f < 40; f++) begin
      int nr;
      int nc;
      nr = $urandom_range(1, 4);
      nc = $urandom_range(1, 8);
      rows_q = {};
      for (int r = 0; r < nr; r++) rows_q.push_back(nc);
      if ($urandom_range(0, 4) == 0) rows_q[$urandom_range(0, nr - 1)] = $urandom_range(1, 9);
      trunc_at = ($urandom_range(0, 5) == 0) ? int'($urandom_range(0, nr - 1)) : -1;
      skip_gap = ($urandom_range(0, 4) == 0);
      send_frame(1'($urandom_range(0, 1)));
      trunc_at = -1;
      skip_gap = 1'b0;
      if ($urandom_range(0, 3) == 0) clear_err();
    end

    // Reset mid-frame drops progress.
    cyc(1'b1, DTYPE_FRAME_START);
    cyc(1'b1, DTYPE_ROW_START);
    cyc(1'b1, pix_type());
    do_reset();
    rows_q = '{4, 4};
    send_frame(1'b0);

    // Frame counter across 300 frames.
    do_reset();
    for (int f = 0; f < 300; f++) begin
      rows_q = '{f % 3 + 1};
      send_frame(1'b0);
    end
    check("fc300", frame_count, 300);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
